// File: rtl/csr_access_unit.sv
// Zicsr execute-stage sequencer: runs a single read-modify-write on the CSR file per op
// and returns the old CSR value to integer writeback.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_csr_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [4:0]        in_rs1_idx,
  input  logic [4:0]        in_rd,
  input  logic              flush,
  output logic              csr_ren,
  output logic [ADDR_W-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              illegal_q, illegal_d;

  logic              read_en;
  logic              write_en;
  logic [XLEN-1:0]   new_val;

  // Write-only swap to x0 skips the read; set/clear with a zero operand skips the write.
  assign read_en  = !((op_q == 2'b01) && (rd_q == 5'd0));
  assign write_en = !(op_q[1] && (rs1_idx_q == 5'd0));

  always_comb begin
    new_val = src_q;
    case (op_q)
      2'b10:   new_val = old_q | src_q;
      2'b11:   new_val = old_q & ~src_q;
      default: new_val = src_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      rs1_idx_q <= '0;
      src_q     <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      rs1_idx_q <= rs1_idx_d;
      src_q     <= src_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    rs1_idx_d  = rs1_idx_q;
    src_d      = src_q;
    old_d      = old_q;
    illegal_d  = illegal_q;
    in_ready   = 1'b0;
    csr_ren    = 1'b0;
    csr_raddr  = '0;
    csr_wen    = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    wb_illegal = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          op_d      = in_funct3[1:0];
          addr_d    = in_csr_addr;
          rd_d      = in_rd;
          rs1_idx_d = in_rs1_idx;
          src_d     = in_funct3[2] ? {{(XLEN-5){1'b0}}, in_rs1_idx} : in_rs1_data;
          old_d     = '0;
          illegal_d = (in_funct3[1:0] == 2'b00);
          state_d   = (in_funct3[1:0] == 2'b00) ? RESP : READ;
        end
      end
      READ: begin
        csr_ren   = read_en;
        csr_raddr = addr_q;
        old_d     = read_en ? csr_rdata : '0;
        state_d   = flush ? IDLE : WRITE;
      end
      WRITE: begin
        csr_wen   = write_en;
        csr_waddr = addr_q;
        csr_wdata = write_en ? new_val : '0;
        state_d   = RESP;
      end
      RESP: begin
        wb_valid   = 1'b1;
        wb_rd      = rd_q;
        wb_data    = illegal_q ? '0 : old_q;
        wb_illegal = illegal_q;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit; a one-register CSR file model at 0x300 answers reads
// combinationally and takes writes on the clock edge.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr_addr;
  logic [31:0] in_rs1_data;
  logic [4:0]  in_rs1_idx;
  logic [4:0]  in_rd;
  logic        flush;
  logic        csr_ren;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_illegal;

  logic        tb_init;
  logic [31:0] csr_300;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_csr_addr(in_csr_addr), .in_rs1_data(in_rs1_data), .in_rs1_idx(in_rs1_idx),
    .in_rd(in_rd), .flush(flush),
    .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_illegal(wb_illegal)
  );

  // Unqualified read data: a gated read must not leak the register into old.
  assign csr_rdata = (csr_raddr == 12'h300) ? csr_300 : 32'hBAD0_0000;

  always @(posedge clk) begin
    if (tb_init) csr_300 <= 32'h0;
    else if (csr_wen && csr_waddr == 12'h300) csr_300 <= csr_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [31:0] data,
                          input logic [4:0] idx, input logic [4:0] rd);
    @(negedge clk);
    in_funct3   = f3;
    in_csr_addr = 12'h300;
    in_rs1_data = data;
    in_rs1_idx  = idx;
    in_rd       = rd;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] data,
                        input logic [4:0] idx, input logic [4:0] rd,
                        input int exp_ren, input int exp_wen, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wb, input logic exp_ill, input int exp_wbcyc);
    int ren_n = 0, wen_n = 0, ren_c = -1, wen_c = -1, wb_c = -1, leak = 0;
    logic [31:0] wd = 0, wa = 0, wbd = 0, wbr = 0;
    logic ill = 1'b0;
    @(negedge clk);
    chk({name, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    start_op(f3, data, idx, rd);
    for (int c = 1; c <= 20 && wb_c < 0; c++) begin
      @(negedge clk);
      if (csr_ren) begin ren_n++; ren_c = c; end
      if (csr_wen) begin wen_n++; wen_c = c; wd = csr_wdata; wa = {20'b0, csr_waddr}; end
      else if (csr_wdata != 32'h0) leak++;
      if (csr_ren && csr_wen) leak++;
      if (in_ready) leak++;
      if (wb_valid) begin
        wb_c = c; wbd = wb_data; wbr = {27'b0, wb_rd}; ill = wb_illegal;
      end
    end
    chk({name, ".ren_count"}, ren_n, exp_ren);
    chk({name, ".wen_count"}, wen_n, exp_wen);
    if (exp_ren != 0) chk({name, ".ren_cycle"}, ren_c, 1);
    if (exp_wen != 0) begin
      chk({name, ".wen_cycle"}, wen_c, 2);
      chk({name, ".wdata"}, wd, exp_wdata);
      chk({name, ".waddr"}, wa, 32'h300);
    end
    chk({name, ".wb_cycle"}, wb_c, exp_wbcyc);
    chk({name, ".wb_rd"}, wbr, {27'b0, rd});
    chk({name, ".wb_data"}, wbd, exp_wb);
    chk({name, ".wb_illegal"}, {31'b0, ill}, {31'b0, exp_ill});
    chk({name, ".leak"}, leak, 0);
    $display("op %-8s f3=%03b rs1=0x%08h idx=%0d rd=%0d ren=%0d wen=%0d wdata=0x%08h wb=0x%08h ill=%0b",
             name, f3, data, idx, rd, ren_n, wen_n, wd, wbd, ill);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1; tb_init = 1'b1;
    in_valid = 1'b0; in_funct3 = '0; in_csr_addr = '0; in_rs1_data = '0;
    in_rs1_idx = '0; in_rd = '0; flush = 1'b0; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.csr_ren", {31'b0, csr_ren}, 32'd0);
    chk("rst.csr_wen", {31'b0, csr_wen}, 32'd0);
    chk("rst.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst.wb_data", wb_data, 32'h0);
    rst = 1'b0; tb_init = 1'b0;

    //      name       f3      rs1_data      idx    rd   ren wen wdata         wb            ill cyc
    run_op("csrrw",   3'b001, 32'h88,       5'd0,  5'd5, 1, 1, 32'h88,      32'h0,        0,  3);
    run_op("csrrs0",  3'b010, 32'h1234,     5'd0,  5'd6, 1, 0, 32'h0,       32'h88,       0,  3);
    run_op("csrrwx0", 3'b001, 32'h88,       5'd3,  5'd0, 0, 1, 32'h88,      32'h0,        0,  3);
    run_op("csrrci",  3'b111, 32'hFFFF_FFFF,5'd8,  5'd7, 1, 1, 32'h80,      32'h88,       0,  3);
    run_op("csrrsi",  3'b110, 32'h0,        5'd3,  5'd7, 1, 1, 32'h83,      32'h80,       0,  3);
    run_op("csrrc",   3'b011, 32'h3,        5'd2,  5'd8, 1, 1, 32'h80,      32'h83,       0,  3);
    run_op("illegal", 3'b100, 32'h55,       5'd1,  5'd9, 0, 0, 32'h0,       32'h0,        1,  1);

    // Flush during READ: abort with no write and no response.
    start_op(3'b001, 32'h55, 5'd0, 5'd1);
    @(negedge clk);
    chk("flr.ren", {31'b0, csr_ren}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flr.in_ready", {31'b0, in_ready}, 32'd1);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (csr_wen || wb_valid) bad++;
      @(negedge clk);
    end
    chk("flr.no_wen_wb", bad, 0);
    chk("flr.csr_kept", csr_300, 32'h80);
    $display("op flush_rd aborted csr=0x%08h", csr_300);

    // Flush while idle blocks acceptance.
    in_funct3 = 3'b001; in_rs1_data = 32'h77; in_rd = 5'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("fli.in_ready", {31'b0, in_ready}, 32'd1);
    chk("fli.csr_ren", {31'b0, csr_ren}, 32'd0);
    $display("op flush_id not accepted");

    // Flush during WRITE is ignored.
    start_op(3'b101, 32'h0, 5'h11, 5'd9);
    @(negedge clk);
    @(negedge clk);
    chk("flw.wen", {31'b0, csr_wen}, 32'd1);
    chk("flw.wdata", csr_wdata, 32'h11);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flw.wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("flw.wb_data", wb_data, 32'h80);
    chk("flw.wb_rd", {27'b0, wb_rd}, 32'd9);
    @(negedge clk);
    chk("flw.csr_new", csr_300, 32'h11);
    $display("op flush_wr committed csr=0x%08h", csr_300);

    // Writeback backpressure: response held stable for 5 cycles.
    wb_ready = 1'b0;
    start_op(3'b010, 32'h100, 5'd4, 5'd10);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall.wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("stall.wb_data", wb_data, 32'h11);
      chk("stall.wb_rd", {27'b0, wb_rd}, 32'd10);
      chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall.release_ready", {31'b0, in_ready}, 32'd1);
    chk("stall.release_valid", {31'b0, wb_valid}, 32'd0);
    chk("stall.csr_new", csr_300, 32'h111);
    $display("op stall   released csr=0x%08h", csr_300);

    // Asynchronous reset while in WRITE drops the pending write.
    start_op(3'b001, 32'hAA, 5'd0, 5'd3);
    @(negedge clk);
    @(negedge clk);
    chk("rstw.wen_before", {31'b0, csr_wen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw.wen", {31'b0, csr_wen}, 32'd0);
    chk("rstw.wdata", csr_wdata, 32'h0);
    chk("rstw.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rstw.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 chk("rstw.csr_kept", csr_300, 32'h111);
    @(negedge clk);
    rst = 1'b0;
    $display("op rst_wr  dropped csr=0x%08h", csr_300);

    run_op("recover", 3'b110, 32'h0, 5'd0, 5'd4, 1, 0, 32'h0, 32'h111, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
